// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD modulo counter with up/down counting, validated synchronous load,
// sticky load-error flag and a combinational terminal count for synchronous cascading.
`timescale 1ns/1ps
module bcd_mod_counter #(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 60
) (
    input  logic                CP,
    input  logic                nCR,
    input  logic                EN,
    input  logic                UP,
    input  logic                LD,
    input  logic [4*DIGITS-1:0] D,
    output logic [4*DIGITS-1:0] Q,
    output logic                TC,
    output logic                ERR
);
    localparam int W = 4 * DIGITS;

    function automatic int pow10(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Shift-and-add-3 conversion so the terminal constant needs no divider.
    function automatic logic [15:0] toBcd(input int unsigned v);
        logic [15:0] b;
        b = '0;
        for (int i = 13; i >= 0; i--) begin
            for (int d = 0; d < 4; d++) begin
                if (b[4*d +: 4] >= 4'd5) b[4*d +: 4] = b[4*d +: 4] + 4'd3;
            end
            b = {b[14:0], v[i]};
        end
        return b;
    endfunction

    if (DIGITS < 1 || DIGITS > 4 || MODULUS < 2 || MODULUS > pow10(DIGITS)) begin : gBadParams
        $fatal(1, "bcd_mod_counter: illegal DIGITS/MODULUS combination");
    end

    localparam logic [15:0] lastFull = toBcd(MODULUS - 1);
    localparam logic [W-1:0] lastBcd = lastFull[W-1:0];

    logic [W-1:0] incVal;
    logic [W-1:0] decVal;
    logic         incCarry;
    logic         decBorrow;
    logic         nibblesOk;
    logic         loadOk;
    logic         atLast;
    logic         atZero;

    assign atLast = (Q == lastBcd);
    assign atZero = (Q == '0);

    always_comb begin
        incVal   = Q;
        incCarry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (incCarry) begin
                if (Q[4*i +: 4] == 4'd9) begin
                    incVal[4*i +: 4] = 4'd0;
                end else begin
                    incVal[4*i +: 4] = Q[4*i +: 4] + 4'd1;
                    incCarry         = 1'b0;
                end
            end
        end
    end

    always_comb begin
        decVal    = Q;
        decBorrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (decBorrow) begin
                if (Q[4*i +: 4] == 4'd0) begin
                    decVal[4*i +: 4] = 4'd9;
                end else begin
                    decVal[4*i +: 4] = Q[4*i +: 4] - 4'd1;
                    decBorrow        = 1'b0;
                end
            end
        end
    end

    // With every nibble a legal digit, a plain unsigned compare orders BCD values numerically.
    always_comb begin
        nibblesOk = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (D[4*i +: 4] > 4'd9) nibblesOk = 1'b0;
        end
        loadOk = nibblesOk && (D <= lastBcd);
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            Q   <= '0;
            ERR <= 1'b0;
        end else if (LD) begin
            if (loadOk) begin
                Q   <= D;
                ERR <= 1'b0;
            end else begin
                ERR <= 1'b1;
            end
        end else if (EN) begin
            if (UP) Q <= atLast ? '0 : incVal;
            else    Q <= atZero ? lastBcd : decVal;
        end
    end

    // Gated by nCR so a stage held in reset never enables its successor.
    assign TC = nCR & EN & ~LD & (UP ? atLast : atZero);

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter: full up-count sweep, vector table for load/down/hold,
// mid-count reset sequence, and a seconds->hours cascade checked against a minute model.
`timescale 1ns/1ps
module tb_bcd_mod_counter;
    typedef struct {
        logic       ld;
        logic       en;
        logic       up;
        logic [7:0] d;
        logic       expTc;
        logic [7:0] expQ;
        logic       expErr;
    } vec_t;

    logic       CP;
    logic       nCR;
    logic       EN;
    logic       UP;
    logic       LD;
    logic [7:0] D;
    logic [7:0] Q;
    logic       TC;
    logic       ERR;

    logic       cEn;
    logic       cLd;
    logic [7:0] cDSec;
    logic [7:0] cDHr;
    logic [7:0] secQ;
    logic [7:0] hrQ;
    logic       secTc;
    logic       hrTc;
    logic       secErr;
    logic       hrErr;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    vec_t       vecs[$];

    bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) dut (
        .CP(CP), .nCR(nCR), .EN(EN), .UP(UP), .LD(LD), .D(D),
        .Q(Q), .TC(TC), .ERR(ERR)
    );

    bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) secStage (
        .CP(CP), .nCR(nCR), .EN(cEn), .UP(1'b1), .LD(cLd), .D(cDSec),
        .Q(secQ), .TC(secTc), .ERR(secErr)
    );

    bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) hrStage (
        .CP(CP), .nCR(nCR), .EN(secTc), .UP(1'b1), .LD(cLd), .D(cDHr),
        .Q(hrQ), .TC(hrTc), .ERR(hrErr)
    );

    // Clock / watchdog
    initial CP = 1'b0;
    always #5 CP = ~CP;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] bcd2(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic addVec(input logic ld, input logic en, input logic up, input logic [7:0] d,
                          input logic tc, input logic [7:0] q, input logic err);
        vec_t v;
        v.ld = ld; v.en = en; v.up = up; v.d = d;
        v.expTc = tc; v.expQ = q; v.expErr = err;
        vecs.push_back(v);
    endtask

    // Driver: apply one vector after an edge, check TC combinationally, then Q/ERR after the next edge.
    task automatic applyVec(input vec_t v, input int idx);
        string nm;
        LD = v.ld; EN = v.en; UP = v.up; D = v.d;
        #1;
        nm = $sformatf("vec%0d_tc", idx);
        check(nm, {7'd0, TC}, {7'd0, v.expTc});
        exp_q.push_back(v.expQ);
        @(posedge CP); #1;
        nm = $sformatf("vec%0d_q", idx);
        check(nm, Q, exp_q.pop_front());
        nm = $sformatf("vec%0d_err", idx);
        check(nm, {7'd0, ERR}, {7'd0, v.expErr});
    endtask

    initial begin
        int m;
        // Q before each row noted on the right
        addVec(1, 0, 1, 8'h01, 0, 8'h01, 0); // 01
        addVec(0, 1, 0, 8'h00, 0, 8'h00, 0); // 01 down
        addVec(0, 1, 0, 8'h00, 1, 8'h59, 0); // 00 down wraps
        addVec(0, 1, 0, 8'h00, 0, 8'h58, 0); // 59
        addVec(1, 0, 1, 8'h37, 0, 8'h37, 0);
        addVec(1, 0, 1, 8'h60, 0, 8'h37, 1); // value == MODULUS rejected
        addVec(1, 0, 1, 8'h3A, 0, 8'h37, 1); // bad nibble rejected
        addVec(0, 0, 1, 8'h00, 0, 8'h37, 1); // hold keeps ERR
        addVec(1, 0, 1, 8'h12, 0, 8'h12, 0);
        addVec(1, 1, 1, 8'h20, 0, 8'h20, 0); // load beats count
        for (int i = 0; i < 5; i++) addVec(0, 0, 1, 8'h00, 0, 8'h20, 0);
        addVec(1, 0, 1, 8'h59, 0, 8'h59, 0);
        addVec(1, 1, 1, 8'h59, 0, 8'h59, 0); // LD masks TC at terminal
        addVec(0, 1, 1, 8'h00, 1, 8'h00, 0); // 59 up wraps
        addVec(1, 0, 1, 8'h0F, 0, 8'h00, 1); // low nibble illegal
        addVec(0, 0, 0, 8'h00, 0, 8'h00, 1); // EN=0 masks TC at zero
        addVec(0, 1, 1, 8'h00, 0, 8'h01, 1); // counting leaves ERR
        addVec(1, 0, 1, 8'hA0, 0, 8'h01, 1); // high nibble illegal
        addVec(1, 0, 1, 8'h10, 0, 8'h10, 0);
        addVec(0, 1, 0, 8'h00, 0, 8'h09, 0); // borrow across digits
        addVec(1, 1, 0, 8'h45, 0, 8'h45, 0); // UP ignored on load
        addVec(1, 0, 1, 8'h99, 0, 8'h45, 1);

        // Reset block
        nCR = 1'b0; EN = 1'b1; UP = 1'b0; LD = 1'b0; D = 8'h00;
        cEn = 1'b0; cLd = 1'b0; cDSec = 8'h00; cDHr = 8'h00;
        #2;
        check("reset_q", Q, 8'h00);
        check("reset_err", {7'd0, ERR}, 8'd0);
        check("reset_tc", {7'd0, TC}, 8'd0);
        UP = 1'b1;
        #10;
        nCR = 1'b1;
        #1;
        check("release_q", Q, 8'h00);

        // Full up-count sweep with wrap
        for (int i = 0; i <= 60; i++) begin
            check($sformatf("up%0d_q", i), Q, bcd2(i % 60));
            check($sformatf("up%0d_tc", i), {7'd0, TC}, {7'd0, (i % 60) == 59});
            @(posedge CP); #1;
        end

        foreach (vecs[i]) applyVec(vecs[i], i);

        // Reset mid-count with a load pending: reset wins and clears ERR
        LD = 1'b1; D = 8'h30; EN = 1'b1; UP = 1'b1;
        #3;
        nCR = 1'b0;
        #1;
        check("midrst_q", Q, 8'h00);
        check("midrst_err", {7'd0, ERR}, 8'd0);
        check("midrst_tc", {7'd0, TC}, 8'd0);
        @(posedge CP); #1;
        check("midrst_edge_q", Q, 8'h00);
        #2;
        nCR = 1'b1; LD = 1'b0;
        #1;
        check("midrst_release_q", Q, 8'h00);
        @(posedge CP); #1;
        check("midrst_resume_q", Q, 8'h01);

        // Hours cascade
        EN = 1'b0;
        cLd = 1'b1; cDSec = 8'h59; cDHr = 8'h23;
        @(posedge CP); #1;
        check("casc_load_sec", secQ, 8'h59);
        check("casc_load_hr", hrQ, 8'h23);
        cLd = 1'b0; cEn = 1'b1;
        #1;
        check("casc_sec_tc", {7'd0, secTc}, 8'd1);
        check("casc_hr_tc", {7'd0, hrTc}, 8'd1);
        m = 23 * 60 + 59;
        for (int i = 0; i < 1500; i++) begin
            @(posedge CP); #1;
            m = (m + 1) % 1440;
            check($sformatf("casc%0d_sec", i), secQ, bcd2(m % 60));
            check($sformatf("casc%0d_hr", i), hrQ, bcd2(m / 60));
        end
        check("casc_sec_err", {7'd0, secErr}, 8'd0);
        check("casc_hr_err", {7'd0, hrErr}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
- Parametrised multi-digit BCD modulo counter. It is the next generation of the single-digit decade counter used by the clock datapath.
- One instance replaces a hand-cascaded chain for seconds/minutes (MODULUS=60) or hours (MODULUS=24).
- Adds up/down counting, synchronous preset for time setting, load validation, and a terminal-count output for cascading instances.

Parameters:
- DIGITS, 2, number of BCD digits; legal range 1..4.
- MODULUS, 60, count range is 0..MODULUS-1; legal range 2..10^DIGITS. An out-of-range value is a fatal elaboration error.

Ports:
- CP  input  1  clock; all state changes on the rising edge.
- nCR  input  1  asynchronous active-low reset.
- EN  input  1  count enable; the counter advances one step per CP edge while high.
- UP  input  1  direction: 1 = increment, 0 = decrement.
- LD  input  1  synchronous load strobe.
- D  input  4*DIGITS  BCD preset value; digit 0 is in bits [3:0].
- Q  output  4*DIGITS  current count, BCD; digit 0 is in bits [3:0].
- TC  output  1  terminal count, combinational, used as the EN of the next cascaded stage.
- ERR  output  1  sticky flag for a rejected load.

Behaviour:
- Reset: nCR low forces Q=0 and ERR=0 immediately, independent of CP. Release is synchronous-safe; the first change after release occurs on the next CP rising edge.
- Priority per CP edge: LD, then EN, then hold. UP has no effect on a load.
- Load:
  - When LD=1, D is checked. It is valid only if every nibble is ≤9 and the decimal value of D is < MODULUS.
  - Valid D: Q<=D and ERR<=0.
  - Invalid D: Q holds and ERR<=1.
  - A load happens even when EN=0. A load cycle never counts.
- Count up (EN=1, LD=0, UP=1):
  - Q increments in BCD. Digit i rolls 9->0 and carries into digit i+1.
  - When Q == MODULUS-1 (BCD), the next value is 0.
- Count down (EN=1, LD=0, UP=0):
  - Q decrements in BCD. Digit i rolls 0->9 and borrows from digit i+1.
  - When Q == 0, the next value is MODULUS-1 (BCD).
- Hold: EN=0 and LD=0 leave Q unchanged. ERR holds unless a load occurs.
- TC = EN & ~LD & (UP ? (Q==MODULUS-1) : (Q==0)).
  - TC is asserted in the cycle before wrap. The next stage advances on the same edge as the wrap.
  - TC is 0 during reset.
- Latency: Q reflects a count or load one CP edge after the request. TC and ERR need no extra pipeline stage.
- Wrap logic must never produce a non-BCD nibble or a value ≥ MODULUS, in either direction.
- Cascading: chaining N instances with TC feeding the next stage's EN gives a synchronous multi-stage counter with no ripple clocking.
- Reset mid-operation: nCR asserted between edges clears Q at once. If LD and nCR are asserted together, reset wins.
- Synthesis constraints:
  - No divide/modulo operators.
  - The terminal constant (MODULUS-1 in BCD) is computed at elaboration.
  - Registers are Q and ERR only.

Test Plan:
- Reset and count up: nCR=0 for 10 ns, then 1; EN=1, UP=1, DIGITS=2, MODULUS=60.
  - Q steps 0x00,0x01…0x09,0x10…0x59, then 0x00.
  - TC is high only while Q=0x59.
- Count down with wrap: load D=0x01, then EN=1, UP=0.
  - Q goes 0x01, 0x00, 0x59, 0x58.
  - TC is high only while Q=0x00.
- Load validation: LD with D=0x37 gives Q=0x37, ERR=0.
  - LD with D=0x60: Q holds at 0x37, ERR=1.
  - LD with D=0x3A: Q holds, ERR stays 1.
  - LD with D=0x12: Q=0x12, ERR=0.
- Simultaneous and hold events: LD=1 and EN=1 with D=0x20 gives Q=0x20, and TC=0 in that cycle.
  - EN=0 for 5 edges: Q is constant.
- Reset mid-count: assert nCR low between edges at Q=0x45.
  - Q=0x00 and ERR=0 before the next edge.
  - Counting resumes from 0x01 on the first edge after release.
- Hours cascade, MODULUS=24: a MODULUS=60 stage's TC drives a MODULUS=24 stage's EN.
  - From 23:59 (0x23, 0x59), one edge gives 00:00.
  - No nibble ever exceeds 9; 0x24 never appears.
